// File: rtl/ex_muldiv.sv
// RV32M multiply/divide unit for the execute stage: one-cycle multiply,
// 32-cycle restoring divide, with a hold request that stalls the front end.
module ex_muldiv #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      i_Clk,
    input  logic                      i_reset,
    input  logic                      i_start,
    input  logic [2:0]                i_op,
    input  logic [DATA_WIDTH-1:0]     i_reg1_data,
    input  logic [DATA_WIDTH-1:0]     i_reg2_data,
    input  logic [REG_ADDR_WIDTH-1:0] i_regd_addr,
    input  logic                      i_flush,
    output logic                      o_hold_req,
    output logic                      o_result_valid,
    output logic [DATA_WIDTH-1:0]     o_result,
    output logic [REG_ADDR_WIDTH-1:0] o_regd_addr
);

    localparam int unsigned W     = DATA_WIDTH;
    localparam int unsigned CNT_W = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned PW    = 2 * W;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [1:0]                op_q, op_d;
    logic [W-1:0]              a_q, a_d;
    logic [W-1:0]              b_q, b_d;
    logic [W-1:0]              rem_q, rem_d;
    logic                      neg_quo_q, neg_quo_d;
    logic                      neg_rem_q, neg_rem_d;
    logic [W-1:0]              result_q, result_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
    logic                      valid_q, valid_d;

    // Multiply datapath: 33-bit extended operands, 2W-bit product
    logic signed [W:0]  mul_a, mul_b;
    logic [PW-1:0]      prod;
    logic [W-1:0]       mul_res;

    always_comb begin
        mul_a   = {(op_q == 2'b01 || op_q == 2'b10) & a_q[W-1], a_q};
        mul_b   = {(op_q == 2'b01) & b_q[W-1], b_q};
        prod    = PW'(mul_a) * PW'(mul_b);
        mul_res = (op_q == 2'b00) ? prod[W-1:0] : prod[PW-1:W];
    end

    // Restoring divide step; a_q shifts the dividend out and the quotient in
    logic [W:0]   shifted, diff;
    logic         qbit;
    logic [W-1:0] rem_nxt, quo_nxt, quo_fin, rem_fin, div_res;

    always_comb begin
        shifted = {rem_q, a_q[W-1]};
        diff    = shifted - {1'b0, b_q};
        qbit    = ~diff[W];
        rem_nxt = qbit ? diff[W-1:0] : shifted[W-1:0];
        quo_nxt = {a_q[W-2:0], qbit};
        quo_fin = neg_quo_q ? -quo_nxt : quo_nxt;
        rem_fin = neg_rem_q ? -rem_nxt : rem_nxt;
        div_res = op_q[1] ? rem_fin : quo_fin;
    end

    logic signed_div, s1, s2;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        rem_d      = rem_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        rd_d       = rd_q;
        valid_d    = 1'b0;
        signed_div = ~i_op[0];
        s1         = i_reg1_data[W-1];
        s2         = i_reg2_data[W-1];

        if (i_flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        op_d = i_op[1:0];
                        rd_d = i_regd_addr;
                        if (!i_op[2]) begin
                            a_d     = i_reg1_data;
                            b_d     = i_reg2_data;
                            state_d = S_MUL;
                        end else if (i_reg2_data == '0) begin
                            result_d = i_op[1] ? i_reg1_data : '1;
                            valid_d  = 1'b1;
                            state_d  = S_DONE;
                        end else begin
                            a_d       = (signed_div && s1) ? -i_reg1_data : i_reg1_data;
                            b_d       = (signed_div && s2) ? -i_reg2_data : i_reg2_data;
                            rem_d     = '0;
                            cnt_d     = '0;
                            neg_quo_d = signed_div & (s1 ^ s2);
                            neg_rem_d = signed_div & s1;
                            state_d   = S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    result_d = mul_res;
                    valid_d  = 1'b1;
                    state_d  = S_DONE;
                end
                S_DIV: begin
                    a_d   = quo_nxt;
                    rem_d = rem_nxt;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(W - 1)) begin
                        result_d = div_res;
                        valid_d  = 1'b1;
                        state_d  = S_DONE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rem_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            rd_q      <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rem_q     <= rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            rd_q      <= rd_d;
            valid_q   <= valid_d;
        end
    end

    // Hold drops in DONE so ID/EX advances on the writeback edge
    assign o_hold_req     = (state_q == S_IDLE && i_start && !i_flush) ||
                            state_q == S_MUL || state_q == S_DIV;
    assign o_result_valid = valid_q;
    assign o_result       = result_q;
    assign o_regd_addr    = rd_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: latency, results, hold request, flush and reset.
module tb_ex_muldiv;

    logic        i_Clk = 1'b0;
    logic        i_reset;
    logic        i_start;
    logic [2:0]  i_op;
    logic [31:0] i_reg1_data;
    logic [31:0] i_reg2_data;
    logic [4:0]  i_regd_addr;
    logic        i_flush;
    logic        o_hold_req;
    logic        o_result_valid;
    logic [31:0] o_result;
    logic [4:0]  o_regd_addr;

    int n_pass  = 0;
    int n_total = 0;
    logic hold0;

    ex_muldiv #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .i_Clk(i_Clk), .i_reset(i_reset), .i_start(i_start), .i_op(i_op),
        .i_reg1_data(i_reg1_data), .i_reg2_data(i_reg2_data),
        .i_regd_addr(i_regd_addr), .i_flush(i_flush), .o_hold_req(o_hold_req),
        .o_result_valid(o_result_valid), .o_result(o_result), .o_regd_addr(o_regd_addr)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    // Present a request in cycle 0, sample hold there, return at start of cycle 1
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        i_start = 1'b1; i_op = op; i_reg1_data = a; i_reg2_data = b; i_regd_addr = rd;
        @(negedge i_Clk);
        hold0 = o_hold_req;
        tick();
        i_start = 1'b0;
    endtask

    // Wait for the strobe from cycle 1 on; inputs are scrambled while waiting
    task automatic wait_strobe(output int lat, output logic [31:0] res, output logic [4:0] rd,
                               output int hc, output logic hs);
        lat = 1; hc = 0; hs = 1'b0; res = '0; rd = '0;
        forever begin
            @(negedge i_Clk);
            if (o_result_valid) begin
                res = o_result; rd = o_regd_addr; hs = o_hold_req;
                break;
            end
            if (o_hold_req) hc++;
            if (lat >= 60) begin
                lat = -1;
                break;
            end
            tick();
            lat++;
            i_reg1_data = $urandom; i_reg2_data = $urandom;
            i_op = 3'($urandom); i_regd_addr = 5'($urandom);
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b0; i_start = 1'b0; i_op = '0; i_reg1_data = '0; i_reg2_data = '0;
        i_regd_addr = '0; i_flush = 1'b0;
        tick(); tick();
        i_reset = 1'b1;
        @(negedge i_Clk);
        n_total++;
        if (o_result_valid !== 1'b0 || o_hold_req !== 1'b0 || o_result !== 32'h0 || o_regd_addr !== 5'h0)
            $display("FAIL reset_state: valid=%b hold=%b result=%h rd=%h, want 0 0 0 0",
                     o_result_valid, o_hold_req, o_result, o_regd_addr);
        else n_pass++;
        tick();
    endtask

    task automatic test_mul();
        logic [2:0]  ops [4] = '{3'b000, 3'b001, 3'b010, 3'b011};
        logic [31:0] exp [4] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
        int lat, hc; logic [31:0] res; logic [4:0] rd; logic hs;
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], 32'hFFFFFFFF, 32'h2, 5'(i + 3));
            wait_strobe(lat, res, rd, hc, hs);
            n_total++;
            if (lat !== 2 || res !== exp[i] || rd !== 5'(i + 3))
                $display("FAIL mul_op%0d: lat=%0d res=%h rd=%0d, want lat=2 res=%h rd=%0d",
                         ops[i], lat, res, rd, exp[i], i + 3);
            else n_pass++;
            n_total++;
            if (hold0 !== 1'b1 || hc !== 1 || hs !== 1'b0)
                $display("FAIL mul_hold%0d: c0=%b mid=%0d strobe=%b, want 1 1 0", ops[i], hold0, hc, hs);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_div();
        logic [2:0]  ops [8] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110, 3'b100, 3'b110};
        logic [31:0] av  [8] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9,
                                 32'd7, 32'd7, 32'd100, 32'd100};
        logic [31:0] bv  [8] = '{32'd2, 32'd2, 32'd2, 32'd2,
                                 32'hFFFFFFFE, 32'hFFFFFFFE, 32'd7, 32'd7};
        logic [31:0] exp [8] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7FFFFFFC, 32'h1,
                                 32'hFFFFFFFD, 32'h1, 32'd14, 32'd2};
        int lat, hc; logic [31:0] res; logic [4:0] rd; logic hs;
        for (int i = 0; i < 8; i++) begin
            issue(ops[i], av[i], bv[i], 5'(20 + i));
            wait_strobe(lat, res, rd, hc, hs);
            n_total++;
            if (lat !== 33 || res !== exp[i] || rd !== 5'(20 + i) || hc !== 32 || hs !== 1'b0)
                $display("FAIL div_vec%0d: lat=%0d res=%h rd=%0d hold=%0d/%b, want lat=33 res=%h rd=%0d hold=32/0",
                         i, lat, res, rd, hc, hs, exp[i], 20 + i);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_corner();
        logic [2:0]  ops [4] = '{3'b101, 3'b110, 3'b100, 3'b110};
        logic [31:0] av  [4] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
        logic [31:0] bv  [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] exp [4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0};
        int          el  [4] = '{1, 1, 33, 33};
        int lat, hc; logic [31:0] res; logic [4:0] rd; logic hs;
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], av[i], bv[i], 5'(11 + i));
            wait_strobe(lat, res, rd, hc, hs);
            n_total++;
            if (lat !== el[i] || res !== exp[i] || rd !== 5'(11 + i) || hold0 !== 1'b1 ||
                hc !== el[i] - 1 || hs !== 1'b0)
                $display("FAIL corner%0d: lat=%0d res=%h rd=%0d hold=%b/%0d/%b, want lat=%0d res=%h rd=%0d hold=1/%0d/0",
                         i, lat, res, rd, hold0, hc, hs, el[i], exp[i], 11 + i, el[i] - 1);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_flush();
        int lat, hc; logic [31:0] res; logic [4:0] rd; logic hs;
        issue(3'b100, 32'd1000, 32'd3, 5'd7);
        repeat (9) tick();
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        n_total++;
        if (o_hold_req !== 1'b0 || o_result_valid !== 1'b0)
            $display("FAIL flush_idle: hold=%b valid=%b, want 0 0", o_hold_req, o_result_valid);
        else n_pass++;
        issue(3'b000, 32'd3, 32'd5, 5'd8);
        wait_strobe(lat, res, rd, hc, hs);
        n_total++;
        if (lat !== 2 || res !== 32'd15 || rd !== 5'd8)
            $display("FAIL flush_mul: lat=%0d res=%h rd=%0d, want lat=2 res=0000000f rd=8", lat, res, rd);
        else n_pass++;
        tick();
        repeat (40) begin
            @(negedge i_Clk);
            if (o_result_valid) hc = 99;
            tick();
        end
        n_total++;
        if (hc === 99) $display("FAIL flush_no_strobe: stray strobe seen, want none");
        else n_pass++;
    endtask

    task automatic test_reset_mid_div();
        int stray = 0;
        issue(3'b100, 32'd1000, 32'd3, 5'd9);
        repeat (5) tick();
        i_reset = 1'b0;
        tick(); tick();
        i_reset = 1'b1;
        @(negedge i_Clk);
        n_total++;
        if (o_hold_req !== 1'b0 || o_result_valid !== 1'b0 || o_result !== 32'h0 || o_regd_addr !== 5'h0)
            $display("FAIL reset_mid_div: hold=%b valid=%b result=%h rd=%h, want 0 0 0 0",
                     o_hold_req, o_result_valid, o_result, o_regd_addr);
        else n_pass++;
        repeat (40) begin
            tick();
            @(negedge i_Clk);
            if (o_result_valid) stray++;
        end
        n_total++;
        if (stray !== 0) $display("FAIL reset_no_strobe: strobes=%0d, want 0", stray);
        else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        int lat, hc; logic [31:0] res; logic [4:0] rd; logic hs;
        int cyc = 1;
        issue(3'b100, 32'd100, 32'd7, 5'd9);
        i_start = 1'b1; i_op = 3'b000; i_reg1_data = 32'd6; i_reg2_data = 32'd7; i_regd_addr = 5'd10;
        forever begin
            @(negedge i_Clk);
            if (o_result_valid || cyc >= 60) break;
            tick();
            cyc++;
        end
        n_total++;
        if (cyc !== 33 || o_result !== 32'd14 || o_regd_addr !== 5'd9 || o_hold_req !== 1'b0)
            $display("FAIL b2b_div: cyc=%0d res=%h rd=%0d hold=%b, want 33 0000000e 9 0",
                     cyc, o_result, o_regd_addr, o_hold_req);
        else n_pass++;
        tick();
        @(negedge i_Clk);
        n_total++;
        if (o_hold_req !== 1'b1 || o_result_valid !== 1'b0)
            $display("FAIL b2b_accept: hold=%b valid=%b, want 1 0", o_hold_req, o_result_valid);
        else n_pass++;
        tick();
        i_start = 1'b0;
        wait_strobe(lat, res, rd, hc, hs);
        n_total++;
        if (lat !== 2 || res !== 32'd42 || rd !== 5'd10)
            $display("FAIL b2b_mul: lat=%0d res=%h rd=%0d, want lat=2 res=0000002a rd=10", lat, res, rd);
        else n_pass++;
        tick();
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_corner();
        test_flush();
        test_reset_mid_div();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Multi-cycle RV32M multiply/divide unit inside the execute stage.
- Consumes operands, rd address and funct3 as latched by the ID/EX pipeline register.
- Raises a hold request that freezes ID/EX and the upstream stages while an operation is in flight.
- Returns a single-cycle result strobe to the EX writeback mux.

Parameters:
- DATA_WIDTH, 32: operand/result width. The iteration counter is clog2(DATA_WIDTH) bits.
- REG_ADDR_WIDTH, 5: rd address width.

Ports:
- i_Clk  input  1  clock; all state changes on the rising edge.
- i_reset  input  1  synchronous, active-low reset. Sampled on the rising edge of i_Clk; low = reset.
- i_start  input  1  request; EX has decoded an OP-class instruction with funct7=0000001.
- i_op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- i_reg1_data  input  DATA_WIDTH  rs1 value (dividend / multiplicand).
- i_reg2_data  input  DATA_WIDTH  rs2 value (divisor / multiplier).
- i_regd_addr  input  REG_ADDR_WIDTH  destination register.
- i_flush  input  1  branch/jump flush from EX; aborts any operation.
- o_hold_req  output  1  stall request to ID/EX and the PC/IF stages.
- o_result_valid  output  1  one-cycle result strobe.
- o_result  output  DATA_WIDTH  result; valid only while o_result_valid=1.
- o_regd_addr  output  REG_ADDR_WIDTH  rd for the result; valid with o_result_valid.

Behaviour:
- States: IDLE, MUL, DIV, DONE.
- Reset (i_reset=0 at a clock edge): state=IDLE, counter=0, o_result=0, o_regd_addr=0, o_result_valid=0. Reset mid-operation discards the operation; no strobe is produced.
- o_hold_req is combinational: 1 when (state==IDLE && i_start && !i_flush) or state is MUL or DIV; otherwise 0. It is 0 in DONE, which lets ID/EX advance in the same edge the result is written.
- IDLE + i_start (cycle 0): latch i_op, operands and i_regd_addr.
  - i_op[2]=0: next state is MUL.
  - i_op[2]=1 and i_reg2_data==0: next state is DONE with the RISC-V divide-by-zero result. DIV/DIVU give 0xFFFFFFFF; REM/REMU give the dividend.
  - i_op[2]=1 otherwise: next state is DIV with counter=0. Load the absolute values for signed ops (DIV/REM) and record the quotient sign (s1^s2) and remainder sign (s1).
- MUL (1 cycle): form the 2*DATA_WIDTH product of 33-bit extended operands.
  - MULH: signed x signed. MULHSU: signed x unsigned. MULHU and MUL: unsigned x unsigned.
  - MUL selects the low word; MULH/MULHSU/MULHU select the high word.
  - Next state is DONE. o_result_valid asserts in cycle 2.
- DIV: restoring radix-2, one quotient bit per cycle, for DATA_WIDTH cycles (counter 0..31).
  - At counter==DATA_WIDTH-1, apply sign correction (negate quotient/remainder as recorded), register the result and go to DONE.
  - o_result_valid asserts in cycle DATA_WIDTH+1 (cycle 33).
- Overflow: DIV 0x80000000 / 0xFFFFFFFF yields 0x80000000, REM yields 0. This falls out of the unsigned magnitude path with no special case, and the bench must check it.
- DONE (1 cycle): o_result_valid=1, o_result and o_regd_addr hold the final value. Next state is IDLE unconditionally; i_start in DONE is ignored.
- o_result_valid is 0 in all states except DONE.
- i_start in MUL/DIV is ignored; latched operands stay stable even if the inputs change.
- i_flush=1 in any state forces IDLE next edge with no strobe. It has priority over i_start. If asserted in DONE, the strobe still fires that cycle, since the result is already committed.
- All arithmetic is modulo 2^DATA_WIDTH; negation is two's complement.

Test Plan:
- Reset: hold i_reset=0 for 2 edges mid-DIV -> state IDLE, o_hold_req=0, o_result_valid=0, o_result=0, and no strobe appears afterwards.
- MUL/MULH: rs1=0xFFFFFFFF, rs2=0x00000002, start at cycle 0 -> o_hold_req=1 in cycles 0–1, strobe in cycle 2 with 0xFFFFFFFE for MUL. MULH gives 0xFFFFFFFF, MULHU gives 0x00000001, MULHSU gives 0xFFFFFFFF.
- DIV/REM signed: rs1=-7 (0xFFFFFFF9), rs2=2 -> strobe in cycle 33. DIV gives 0xFFFFFFFD (-3), REM gives 0xFFFFFFFF (-1), DIVU gives 0x7FFFFFFC, REMU gives 1. o_regd_addr equals the latched rd.
- Corner cases: DIVU 5/0 -> strobe in cycle 1 with 0xFFFFFFFF, o_hold_req high only in cycle 0. REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 in cycle 33.
- Flush: start DIV, assert i_flush in cycle 10 -> IDLE at cycle 11, o_hold_req=0, no strobe. A new MUL started in cycle 11 completes normally in cycle 13.
- Back-to-back: DIV strobe in cycle 33 with i_start already high for the next MUL -> the MUL is accepted in cycle 34 (IDLE) and strobes in cycle 36. The first result is unchanged by the input changes during DIV.
